sd_req_arbiter: RTL

//  Shares one SD-card host block port between up to 4 drive instances (157x/1581 units).

---
 rtl/sd_req_arbiter_pkg.sv | 24 ++
 rtl/sd_req_arbiter_if.sv | 21 ++
 rtl/sd_req_arbiter_rr_pick.sv | 30 +++
 rtl/sd_req_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sd_req_arbiter_pkg.sv
// Shared types and helpers for the SD-card host-port request arbiter.
// Several drive requesters share one host port.
package sd_req_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        REQ   = 3'd2,
        XFER  = 3'd3,
        DONE  = 3'd4
    } sdarb_state_t;

    localparam int NDR_MAX = 4;
    localparam int TO_W    = 25;

    typedef logic [31:0] lba_t;
    typedef logic [5:0]  blk_cnt_t;

    // Round-robin successor of a drive index within 0..ndr-1
    function automatic logic [1:0] next_idx(input logic [1:0] idx, input int ndr);
        next_idx = (idx == 2'(ndr - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/sd_req_arbiter_if.sv
// Single SD-card host block port as seen by the arbiter (master) and host (slave).
interface sd_req_arbiter_if;
    import sd_req_arbiter_pkg::*;

    logic       host_rd;
    logic       host_wr;
    lba_t       host_lba;
    blk_cnt_t   host_blk_cnt;
    logic [7:0] host_buff_din;
    logic       host_ack;

    modport master (
        output host_rd, host_wr, host_lba, host_blk_cnt, host_buff_din,
        input  host_ack
    );

    modport slave (
        input  host_rd, host_wr, host_lba, host_blk_cnt, host_buff_din,
        output host_ack
    );
endinterface

// File: rtl/sd_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module sd_req_arbiter_rr_pick
    import sd_req_arbiter_pkg::*;
#(
    parameter int NDR = 2
) (
    input  logic [NDR_MAX-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         gnt_idx,
    output logic               gnt_vld
);

    logic [1:0] cand_s;
    logic       hit_s;

    // Scan NDR candidates starting at ptr; the first hit wins
    always_comb begin
        gnt_idx = 2'd0;
        gnt_vld = 1'b0;
        cand_s  = 2'd0;
        hit_s   = 1'b0;
        for (int k = 0; k < NDR; k++) begin
            cand_s  = 2'((int'(ptr) + k) % NDR);
            hit_s   = !gnt_vld && req[cand_s];
            gnt_idx = hit_s ? cand_s : gnt_idx;
            gnt_vld = gnt_vld | hit_s;
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one SD-card host block port between up to four drives:
// grants one request at a time, forwards it, routes ack back and muxes write data.
module sd_req_arbiter
    import sd_req_arbiter_pkg::*;
#(
    parameter int  DRIVES      = 2,
    parameter int  TIMEOUT_CYC = 2**24,
    localparam int NDR = (DRIVES < 1) ? 1 : ((DRIVES > NDR_MAX) ? NDR_MAX : DRIVES)
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [NDR-1:0]         drv_rd,
    input  logic [NDR-1:0]         drv_wr,
    input  lba_t [NDR-1:0]         drv_lba,
    input  blk_cnt_t [NDR-1:0]     drv_blk_cnt,
    input  logic [NDR-1:0][7:0]    drv_buff_din,
    output logic [NDR-1:0]         drv_ack,
    sd_req_arbiter_if.master       host,
    output logic                   busy,
    output logic [1:0]             owner,
    output logic                   timeout
);

    localparam bit              TO_EN     = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0] TO_LIM_M1 = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_SAT    = {TO_W{1'b1}};

    sdarb_state_t state_r, state_nxt;

    logic [NDR_MAX-1:0]      rd_ext_s, wr_ext_s, req_ext_s;
    lba_t [NDR_MAX-1:0]      lba_ext_s;
    blk_cnt_t [NDR_MAX-1:0]  blk_ext_s;
    logic [NDR_MAX-1:0][7:0] din_ext_s;

    logic [1:0]      gnt_idx_s, rr_ptr_r, owner_r;
    logic            gnt_vld_s, own_req_s, to_hit_s, timeout_set_s, route_s;
    logic            dir_wr_r, host_rd_r, host_wr_r, busy_r, timeout_r;
    lba_t            lba_r;
    blk_cnt_t        blk_r;
    logic [TO_W-1:0] to_cnt_r;

    // Widen per-drive buses to NDR_MAX so owner/pointer indexing never leaves range
    for (genvar i = 0; i < NDR_MAX; i++) begin : g_ext
        if (i < NDR) begin : g_on
            assign rd_ext_s[i]  = drv_rd[i];
            assign wr_ext_s[i]  = drv_wr[i];
            assign lba_ext_s[i] = drv_lba[i];
            assign blk_ext_s[i] = drv_blk_cnt[i];
            assign din_ext_s[i] = drv_buff_din[i];
            assign drv_ack[i]   = route_s & host.host_ack & (owner_r == 2'(i));
        end else begin : g_off
            assign rd_ext_s[i]  = 1'b0;
            assign wr_ext_s[i]  = 1'b0;
            assign lba_ext_s[i] = 32'h0000_0000;
            assign blk_ext_s[i] = 6'd0;
            assign din_ext_s[i] = 8'h00;
        end
    end

    assign req_ext_s = rd_ext_s | wr_ext_s;
    assign own_req_s = req_ext_s[owner_r];
    // The host may raise ack while still in REQ; the owner sees it that same cycle
    assign route_s   = (state_r == REQ) || (state_r == XFER);

    sd_req_arbiter_rr_pick #(.NDR(NDR)) u_pick (
        .req     (req_ext_s),
        .ptr     (rr_ptr_r),
        .gnt_idx (gnt_idx_s),
        .gnt_vld (gnt_vld_s)
    );

    // FSM state register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_r <= IDLE;
        else          state_r <= state_nxt;
    end

    // Next-state logic; ack beats abort, abort beats timeout
    always_comb begin
        state_nxt = state_r;
        to_hit_s  = TO_EN && (to_cnt_r == TO_LIM_M1);
        case (state_r)
            IDLE:  if (gnt_vld_s) state_nxt = GRANT; else state_nxt = IDLE;
            GRANT: state_nxt = REQ;
            REQ: begin
                if (host.host_ack)               state_nxt = XFER;
                else if (!own_req_s || to_hit_s) state_nxt = IDLE;
                else                             state_nxt = REQ;
            end
            XFER:  if (!host.host_ack) state_nxt = DONE; else state_nxt = XFER;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign timeout_set_s = (state_r == REQ) && !host.host_ack && own_req_s && to_hit_s;

    // Request latches, host strobes, timeout counter and round-robin pointer
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_r  <= 2'd0;
            owner_r   <= 2'd0;
            dir_wr_r  <= 1'b0;
            host_rd_r <= 1'b0;
            host_wr_r <= 1'b0;
            lba_r     <= 32'h0000_0000;
            blk_r     <= 6'd0;
            to_cnt_r  <= {TO_W{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            busy_r    <= (state_nxt != IDLE);
            timeout_r <= timeout_set_s;
            case (state_r)
                IDLE: begin
                    if (gnt_vld_s) begin
                        owner_r  <= gnt_idx_s;
                        dir_wr_r <= wr_ext_s[gnt_idx_s];
                        lba_r    <= lba_ext_s[gnt_idx_s];
                        blk_r    <= blk_ext_s[gnt_idx_s];
                    end
                end
                GRANT: begin
                    host_rd_r <= ~dir_wr_r;
                    host_wr_r <= dir_wr_r;
                    to_cnt_r  <= {TO_W{1'b0}};
                end
                REQ: begin
                    if (state_nxt == REQ) begin
                        if (to_cnt_r != TO_SAT) to_cnt_r <= to_cnt_r + 25'd1;
                    end else begin
                        host_rd_r <= 1'b0;
                        host_wr_r <= 1'b0;
                        // Abort or timeout: step past the faulting owner
                        if (state_nxt == IDLE) rr_ptr_r <= next_idx(owner_r, NDR);
                    end
                end
                DONE: rr_ptr_r <= next_idx(owner_r, NDR);
                default: begin end
            endcase
        end
    end

    assign host.host_rd       = host_rd_r;
    assign host.host_wr       = host_wr_r;
    assign host.host_lba      = lba_r;
    assign host.host_blk_cnt  = blk_r;
    assign host.host_buff_din = (state_r != IDLE) ? din_ext_s[owner_r] : 8'h00;
    assign busy               = busy_r;
    assign owner              = owner_r;
    assign timeout            = timeout_r;

endmodule
